// File: rtl/glyph_layer_sched.sv
// Picks the highest-priority glyph layer covering (hcount, vcount), addresses the glyph ROM for it and delivers pixel/pix_en/bright.
// Latency: fixed 3 clk from inputs to pixel/pix_en/bright; rom_addr is registered 1 clk after inputs.
// Backpressure: none; the pipeline advances every clock and never stalls.
module glyph_layer_sched #(
  parameter int DATA_WIDTH  = 24,
  parameter int N_SPR       = 4,
  parameter int SPR_SEL_W   = 2,
  parameter int COORD_W     = 10,
  parameter int GLYPH_LOG2  = 4,
  parameter int GLYPH_IDX_W = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [COORD_W-1:0]                   hcount,
  input  logic [COORD_W-1:0]                   vcount,
  input  logic                                 bright_in,
  input  logic                                 frame_start,
  input  logic                                 cfg_we,
  input  logic [SPR_SEL_W-1:0]                 cfg_sel,
  input  logic [1:0]                           cfg_field,
  input  logic [COORD_W-1:0]                   cfg_data,
  output logic [GLYPH_IDX_W+2*GLYPH_LOG2-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]                rom_data,
  output logic [DATA_WIDTH-1:0]                pixel,
  output logic                                 pix_en,
  output logic                                 bright
);

  localparam int ADDR_W = GLYPH_IDX_W + 2 * GLYPH_LOG2;
  localparam logic [COORD_W-1:0] GLYPH_SZ = COORD_W'(1 << GLYPH_LOG2);

  // Shadow copy: written by the config port at any time
  logic [COORD_W-1:0]     sh_x_q   [N_SPR];
  logic [COORD_W-1:0]     sh_x_d   [N_SPR];
  logic [COORD_W-1:0]     sh_y_q   [N_SPR];
  logic [COORD_W-1:0]     sh_y_d   [N_SPR];
  logic [GLYPH_IDX_W-1:0] sh_idx_q [N_SPR];
  logic [GLYPH_IDX_W-1:0] sh_idx_d [N_SPR];
  logic [N_SPR-1:0]       sh_en_q;
  logic [N_SPR-1:0]       sh_en_d;

  // Active copy: what the hit test uses; only moves on frame_start
  logic [COORD_W-1:0]     act_x_q   [N_SPR];
  logic [COORD_W-1:0]     act_x_d   [N_SPR];
  logic [COORD_W-1:0]     act_y_q   [N_SPR];
  logic [COORD_W-1:0]     act_y_d   [N_SPR];
  logic [GLYPH_IDX_W-1:0] act_idx_q [N_SPR];
  logic [GLYPH_IDX_W-1:0] act_idx_d [N_SPR];
  logic [N_SPR-1:0]       act_en_q;
  logic [N_SPR-1:0]       act_en_d;

  // Hit test results
  logic [COORD_W-1:0]     dx_w [N_SPR];
  logic [COORD_W-1:0]     dy_w [N_SPR];
  logic [N_SPR-1:0]       hit_w;
  logic                   any_hit_w;
  logic [ADDR_W-1:0]      addr_w;

  // Pipeline registers
  logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
  logic                   v1_q, v1_d;
  logic                   b1_q, b1_d;
  logic                   v2_q, v2_d;
  logic                   b2_q, b2_d;
  logic [DATA_WIDTH-1:0]  pixel_q, pixel_d;
  logic                   pix_en_q, pix_en_d;
  logic                   bright_q, bright_d;

  // Shadow update from the config port; out-of-range selects match no layer
  always_comb begin
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    sh_idx_d = sh_idx_q;
    sh_en_d  = sh_en_q;
    for (int i = 0; i < N_SPR; i++) begin
      if (cfg_we && (cfg_sel == SPR_SEL_W'(i))) begin
        case (cfg_field)
          2'd0:    sh_x_d[i]   = cfg_data;
          2'd1:    sh_y_d[i]   = cfg_data;
          2'd2:    sh_idx_d[i] = cfg_data[GLYPH_IDX_W-1:0];
          default: sh_en_d[i]  = cfg_data[0];
        endcase
      end
    end
  end

  // Frame-boundary copy takes the post-write shadow so a coincident write lands
  always_comb begin
    act_x_d   = act_x_q;
    act_y_d   = act_y_q;
    act_idx_d = act_idx_q;
    act_en_d  = act_en_q;
    if (frame_start) begin
      act_x_d   = sh_x_d;
      act_y_d   = sh_y_d;
      act_idx_d = sh_idx_d;
      act_en_d  = sh_en_d;
    end
  end

  // Per-layer coverage; explicit >= compares stop modular wrap-around hits
  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    assign dx_w[g]  = hcount - act_x_q[g];
    assign dy_w[g]  = vcount - act_y_q[g];
    assign hit_w[g] = act_en_q[g] & (hcount >= act_x_q[g]) & (dx_w[g] < GLYPH_SZ)
                    & (vcount >= act_y_q[g]) & (dy_w[g] < GLYPH_SZ);
  end

  assign any_hit_w = |hit_w;

  // Priority select: scan from the lowest priority so layer 0 overwrites last
  always_comb begin
    addr_w = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit_w[i]) begin
        addr_w = {act_idx_q[i], dy_w[i][GLYPH_LOG2-1:0], dx_w[i][GLYPH_LOG2-1:0]};
      end
    end
  end

  // Three-stage datapath: address issue, ROM access, output capture
  always_comb begin
    rom_addr_d = addr_w;
    v1_d       = any_hit_w & bright_in;
    b1_d       = bright_in;
    v2_d       = v1_q;
    b2_d       = b1_q;
    pixel_d    = v2_q ? rom_data : '0;
    pix_en_d   = v2_q;
    bright_d   = b2_q;
  end

  // Configuration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_x_q    <= '{default: '0};
      sh_y_q    <= '{default: '0};
      sh_idx_q  <= '{default: '0};
      sh_en_q   <= '0;
      act_x_q   <= '{default: '0};
      act_y_q   <= '{default: '0};
      act_idx_q <= '{default: '0};
      act_en_q  <= '0;
    end else begin
      sh_x_q    <= sh_x_d;
      sh_y_q    <= sh_y_d;
      sh_idx_q  <= sh_idx_d;
      sh_en_q   <= sh_en_d;
      act_x_q   <= act_x_d;
      act_y_q   <= act_y_d;
      act_idx_q <= act_idx_d;
      act_en_q  <= act_en_d;
    end
  end

  // Pipeline registers; reset clears outputs immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q <= '0;
      v1_q       <= 1'b0;
      b1_q       <= 1'b0;
      v2_q       <= 1'b0;
      b2_q       <= 1'b0;
      pixel_q    <= '0;
      pix_en_q   <= 1'b0;
      bright_q   <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      v1_q       <= v1_d;
      b1_q       <= b1_d;
      v2_q       <= v2_d;
      b2_q       <= b2_d;
      pixel_q    <= pixel_d;
      pix_en_q   <= pix_en_d;
      bright_q   <= bright_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pixel    = pixel_q;
  assign pix_en   = pix_en_q;
  assign bright   = bright_q;

endmodule

// File: tb/tb_glyph_layer_sched.sv
// Bench for glyph_layer_sched: one 4-layer instance and one 3-layer instance share stimulus.
// Expected values come from a coordinate-arithmetic model with shadow/active config arrays.
// Outputs are sampled 1 time unit after each rising edge.
module tb_glyph_layer_sched;

  logic        clk;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic        bright_in, frame_start, cfg_we;
  logic [1:0]  cfg_sel, cfg_field;
  logic [9:0]  cfg_data;
  logic [13:0] rom_addr_a, rom_addr_b;
  logic [23:0] rom_data_a, rom_data_b;
  logic [23:0] pixel_a, pixel_b;
  logic        pix_en_a, pix_en_b, bright_a, bright_b;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [13:0] addr;
    logic        v;
    logic        b;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // model config state: [instance][layer]
  int m_sx[2][4], m_sy[2][4], m_sidx[2][4], m_sen[2][4];
  int m_ax[2][4], m_ay[2][4], m_aidx[2][4], m_aen[2][4];

  glyph_layer_sched #(.N_SPR(4), .SPR_SEL_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .bright_in(bright_in), .frame_start(frame_start), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .pixel(pixel_a), .pix_en(pix_en_a), .bright(bright_a)
  );

  glyph_layer_sched #(.N_SPR(3), .SPR_SEL_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .bright_in(bright_in), .frame_start(frame_start), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .pixel(pixel_b), .pix_en(pix_en_b), .bright(bright_b)
  );

  function automatic logic [23:0] rom_f(input logic [13:0] a);
    rom_f = {a[9:0], a} ^ 24'hA5C396;
  endfunction

  // synchronous glyph ROM, one per instance
  always @(posedge clk) begin
    rom_data_a <= rom_f(rom_addr_a);
    rom_data_b <= rom_f(rom_addr_b);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nspr(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  // what the hardware should show for this position under the current active config
  function automatic exp_t model(input int k, input int h, input int v, input bit bi);
    exp_t e;
    bit found;
    e = '0;
    found = 0;
    for (int i = 0; i < nspr(k); i++) begin
      if (!found && m_aen[k][i] != 0 && h >= m_ax[k][i] && (h - m_ax[k][i]) < 16 &&
          v >= m_ay[k][i] && (v - m_ay[k][i]) < 16) begin
        found  = 1;
        e.addr = 14'(m_aidx[k][i] * 256 + (v - m_ay[k][i]) * 16 + (h - m_ax[k][i]));
      end
    end
    e.v = found & bi;
    e.b = bi;
    return e;
  endfunction

  task automatic upd_model(input bit we, input int sel, input int fld, input int dat, input bit fs);
    for (int k = 0; k < 2; k++) begin
      if (we && sel < nspr(k)) begin
        case (fld)
          0: m_sx[k][sel] = dat;
          1: m_sy[k][sel] = dat;
          2: m_sidx[k][sel] = dat % 64;
          default: m_sen[k][sel] = dat % 2;
        endcase
      end
      if (fs) begin
        for (int i = 0; i < 4; i++) begin
          m_ax[k][i] = m_sx[k][i];
          m_ay[k][i] = m_sy[k][i];
          m_aidx[k][i] = m_sidx[k][i];
          m_aen[k][i] = m_sen[k][i];
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_sx[k][i] = 0; m_sy[k][i] = 0; m_sidx[k][i] = 0; m_sen[k][i] = 0;
        m_ax[k][i] = 0; m_ay[k][i] = 0; m_aidx[k][i] = 0; m_aen[k][i] = 0;
      end
    end
    qa.delete();
    qb.delete();
    // two cleared pipeline stages sit ahead of the first real input
    qa.push_back('0); qa.push_back('0);
    qb.push_back('0); qb.push_back('0);
  endtask

  // one clock: drive inputs, advance, check address now and output of 3 cycles ago
  task automatic step(input int h, input int v, input bit bi, input bit fs,
                      input bit we, input int sel, input int fld, input int dat);
    exp_t ea, eb, oa, ob;
    logic [31:0] tmp;
    tmp = h;   hcount = tmp[9:0];
    tmp = v;   vcount = tmp[9:0];
    tmp = sel; cfg_sel = tmp[1:0];
    tmp = fld; cfg_field = tmp[1:0];
    tmp = dat; cfg_data = tmp[9:0];
    bright_in = bi;
    frame_start = fs;
    cfg_we = we;
    ea = model(0, h, v, bi);
    eb = model(1, h, v, bi);
    upd_model(we, sel, fld, dat, fs);
    @(posedge clk);
    #1;
    qa.push_back(ea);
    qb.push_back(eb);
    chk("rom_addr_a", 32'(rom_addr_a), 32'(ea.addr));
    chk("rom_addr_b", 32'(rom_addr_b), 32'(eb.addr));
    if (qa.size() >= 3) begin
      oa = qa.pop_front();
      chk("pixel_a", 32'(pixel_a), oa.v ? 32'(rom_f(oa.addr)) : 32'd0);
      chk("pix_en_a", 32'(pix_en_a), 32'(oa.v));
      chk("bright_a", 32'(bright_a), 32'(oa.b));
    end
    if (qb.size() >= 3) begin
      ob = qb.pop_front();
      chk("pixel_b", 32'(pixel_b), ob.v ? 32'(rom_f(ob.addr)) : 32'd0);
      chk("pix_en_b", 32'(pix_en_b), 32'(ob.v));
      chk("bright_b", 32'(bright_b), 32'(ob.b));
    end
  endtask

  task automatic idle(input int h, input int v, input bit bi);
    step(h, v, bi, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic wr(input int sel, input int fld, input int dat, input bit fs);
    step(0, 0, 1'b0, fs, 1'b1, sel, fld, dat);
  endtask

  task automatic set_layer(input int sel, input int x, input int y, input int idx, input int en);
    wr(sel, 0, x, 1'b0);
    wr(sel, 1, y, 1'b0);
    wr(sel, 2, idx, 1'b0);
    wr(sel, 3, en, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_we = 1'b0;
    frame_start = 1'b0;
    #1;
    chk("rst_addr_a", 32'(rom_addr_a), 32'd0);
    chk("rst_pixel_a", 32'(pixel_a), 32'd0);
    chk("rst_pix_en_a", 32'(pix_en_a), 32'd0);
    chk("rst_bright_a", 32'(bright_a), 32'd0);
    chk("rst_addr_b", 32'(rom_addr_b), 32'd0);
    chk("rst_pix_en_b", 32'(pix_en_b), 32'd0);
    chk("rst_bright_b", 32'(bright_b), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_cycles(input int n);
    int h, v, dat;
    bit bi, fs, we;
    for (int c = 0; c < n; c++) begin
      h   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 90);
      v   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 90);
      dat = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 75);
      bi  = ($urandom_range(0, 3) != 0);
      fs  = ($urandom_range(0, 15) == 0);
      we  = ($urandom_range(0, 2) == 0);
      step(h, v, bi, fs, we, $urandom_range(0, 3), $urandom_range(0, 3), dat);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    hcount = '0; vcount = '0; bright_in = 1'b0; frame_start = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_field = '0; cfg_data = '0;
    model_reset();
    #2;
    do_reset();

    // no config: every position, visible or not, yields no hit
    for (int i = 0; i < 6; i++) idle(i * 17, i * 9, 1'b1);
    chk("noconfig_pix_en", 32'(pix_en_a), 32'd0);

    // single layer L0 at (100,50) glyph 3
    set_layer(0, 100, 50, 3, 1);
    wr(0, 3, 1, 1'b1);
    idle(105, 52, 1'b1);
    chk("single_addr", 32'(rom_addr_a), 32'(14'({6'd3, 4'd2, 4'd5})));
    idle(0, 0, 1'b0);
    idle(0, 0, 1'b0);
    chk("single_pix_en", 32'(pix_en_a), 32'd1);
    chk("single_pixel", 32'(pixel_a), 32'(rom_f(14'({6'd3, 4'd2, 4'd5}))));

    // glyph edges
    idle(115, 52, 1'b1);
    chk("edge_dx15", 32'(rom_addr_a), 32'(14'({6'd3, 4'd2, 4'd15})));
    idle(116, 52, 1'b1);
    chk("edge_dx16", 32'(rom_addr_a), 32'd0);
    idle(99, 52, 1'b1);
    idle(105, 66, 1'b1);
    idle(105, 65, 1'b1);
    idle(105, 49, 1'b1);

    // no wrap-around at the right edge of the coordinate space
    wr(0, 0, 1020, 1'b1);
    idle(0, 52, 1'b1);
    chk("nowrap_h0", 32'(rom_addr_a), 32'd0);
    idle(3, 52, 1'b1);
    idle(1023, 52, 1'b1);
    idle(1020, 50, 1'b1);

    // priority: L0 beats L2; after disabling L0 L2 takes over
    set_layer(0, 200, 200, 3, 1);
    set_layer(2, 195, 198, 9, 1);
    wr(2, 3, 1, 1'b1);
    idle(200, 200, 1'b1);
    chk("prio_l0", 32'(rom_addr_a[13:8]), 32'd3);
    wr(0, 3, 0, 1'b1);
    idle(200, 200, 1'b1);
    chk("prio_l2", 32'(rom_addr_a[13:8]), 32'd9);
    wr(0, 3, 1, 1'b1);

    // shadow: mid-frame write has no effect until frame_start
    wr(0, 0, 300, 1'b0);
    idle(205, 205, 1'b1);
    idle(305, 205, 1'b1);
    wr(0, 0, 310, 1'b1);
    idle(312, 205, 1'b1);
    chk("shadow_bypass", 32'(rom_addr_a), 32'(14'({6'd3, 4'd5, 4'd2})));
    idle(305, 205, 1'b1);

    // blanking: hit with bright_in low
    idle(315, 210, 1'b0);
    idle(315, 210, 1'b0);
    idle(315, 210, 1'b0);
    chk("blank_pix_en", 32'(pix_en_a), 32'd0);
    chk("blank_bright", 32'(bright_a), 32'd0);

    // select 3 exists on the 4-layer instance only
    set_layer(3, 500, 500, 42, 1);
    wr(3, 3, 1, 1'b1);
    idle(507, 503, 1'b1);
    chk("sel3_b_ignored", 32'(rom_addr_b), 32'd0);
    idle(508, 509, 1'b1);
    idle(0, 0, 1'b0);
    idle(0, 0, 1'b0);

    // random traffic, then reset in the middle of it
    rand_cycles(2500);
    do_reset();
    for (int i = 0; i < 8; i++) idle($urandom_range(0, 90), $urandom_range(0, 90), 1'b1);
    chk("post_rst_pix_en", 32'(pix_en_a), 32'd0);
    rand_cycles(2500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
